cpu_run_controller: RTL
=======================

# cpu_run_controller

Parametrised run/reset sequencer for one or more RISC-V cores. It holds each core in reset until its program image is loaded. Each core is released on a debounced press of the board run button, and the block then supports halt, resume and single-step via the run and step buttons. It sits between the board buttons and program loader on one side and each core's reset and clock-enable inputs on the other.

## Interface
Parameters:
- NUM_CORES, 1, number of independently sequenced cores
- SYNC_STAGES, 2, flip-flops in each button synchroniser (≥2)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change (≥1)
- HOLD_CYCLES, 16, minimum cycles cpu_reset stays asserted after entering RESET (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run_btn  in  1  raw run button, asynchronous to clk
- step_btn  in  1  raw step button, asynchronous to clk
- load_done  in  NUM_CORES  per-core image-loaded level from the loader
- soft_reset  in  NUM_CORES  per-core synchronous reset request, level
- cpu_reset  out  NUM_CORES  per-core core reset, active-high
- cpu_en  out  NUM_CORES  per-core core clock-enable
- core_state  out  2*NUM_CORES  per-core state encoding, core i at bits [2i+1:2i]

## Operation
Button path, per button:
- SYNC_STAGES synchroniser, then debounce.
- Debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the current level clears the counter.
- A registered one-cycle pulse (run_pulse / step_pulse) fires on the cycle the debounced level rises. Falling edges produce nothing.

Per-core FSM, encoding RESET=0, ARMED=1, RUNNING=2, HALTED=3. Transitions are evaluated in this priority order:
- Any state, soft_reset[i]=1 → RESET, hold counter reloaded.
- RUNNING or HALTED or ARMED, load_done[i]=0 → RESET, hold counter reloaded.
- RESET: hold counter decrements to 0. Move to ARMED when the counter is 0 and load_done[i]=1. run_pulse is ignored here and not queued.
- ARMED → RUNNING on run_pulse.
- RUNNING → HALTED on run_pulse.
- HALTED → RUNNING on run_pulse. step_pulse without run_pulse keeps HALTED and produces one cpu_en cycle. If run_pulse and step_pulse coincide, run wins and the step is dropped.

Outputs, all registered and decoded from the next state:
- cpu_reset[i] = 1 in RESET and ARMED, 0 otherwise.
- cpu_en[i] = 1 in RUNNING, 1 for exactly one cycle per accepted step, 0 otherwise.
- One run_pulse acts on all cores simultaneously, each according to its own state. Cores in RESET are unaffected.

## Timing
- Reset values: cpu_reset all ones, cpu_en all zeros, core_state all RESET, hold counters = HOLD_CYCLES, debounced levels 0, pulses 0, synchronisers 0.
- reset_n assertion takes effect immediately, mid-operation included. Release is synchronous to the first clk edge after deassertion.
- Button latency: the button rises before edge 0. The pulse is high after edge SYNC_STAGES+DEBOUNCE_CYCLES, and FSM outputs change at the next edge. Total is SYNC_STAGES+DEBOUNCE_CYCLES+1 edges; for 2/4 that is 7.
- RESET minimum dwell: cpu_reset stays high for ≥HOLD_CYCLES cycles after entering RESET, regardless of load_done.
- Step pulse: cpu_en high for exactly one cycle, one edge after step_pulse.
- A button held indefinitely generates a single pulse. A new pulse requires the debounced level to fall and rise again.

## Structure
- Package run_ctrl_pkg holds:
  - typedef enum logic [1:0] core_state_t {RESET, ARMED, RUNNING, HALTED}
  - the hold-counter width function $clog2(HOLD_CYCLES+1)
- Sub-module btn_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, reset_n, btn_i, level_o, rise_o), instantiated twice.
- Per-core FSM and hold counter sit in a generate loop in the top module.

## Test plan
All scenarios use NUM_CORES=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=3.
- Reset, then load_done=2'b11 immediately → cpu_reset stays 2'b11 for 3 cycles, then core_state=ARMED for both. Run held 10 cycles → cpu_reset=2'b00 and cpu_en=2'b11 exactly 7 edges after the press.
- Run glitch high for 3 cycles, then low → no pulse, state stays ARMED. Glitch of 4 cycles → exactly one transition.
- RUNNING, then run press → HALTED with cpu_en=0. Step press → cpu_en=1 for exactly one cycle. A second run press → RUNNING.
- load_done=2'b01 and run press → core0 RUNNING, core1 stays RESET with cpu_reset[1]=1. Later load_done[1]=1 needs its own run press.
- Run and step debounced pulses coincide in HALTED → RUNNING, no extra single-cycle step artefact. soft_reset[0] asserted while RUNNING → core0 RESET next edge and cpu_reset[0] high ≥3 cycles, core1 unaffected.
- reset_n pulsed low mid-RUNNING between clock edges → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and sizing helpers for the core run/reset sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    HALTED  = 2'd3
  } core_state_t;

  function automatic int hold_cnt_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchroniser chain, consecutive-cycle debounce and a
// registered rising-edge pulse on the debounced level.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   level_prev_q;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign level_o  = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreement restarts the qualification window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_bit == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= sync_bit;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_prev_q <= 1'b0;
      rise_o       <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      rise_o       <= level_q & ~level_prev_q;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/reset sequencer: debounced run/step buttons drive an independent
// reset/armed/running/halted FSM per core.
module cpu_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CORES       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run_btn,
  input  logic                   step_btn,
  input  logic [NUM_CORES-1:0]   load_done,
  input  logic [NUM_CORES-1:0]   soft_reset,
  output logic [NUM_CORES-1:0]   cpu_reset,
  output logic [NUM_CORES-1:0]   cpu_en,
  output logic [2*NUM_CORES-1:0] core_state
);

  localparam int HW = hold_cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  logic run_pulse;
  logic step_pulse;
  logic run_level_unused;
  logic step_level_unused;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (run_btn),
    .level_o(run_level_unused),
    .rise_o (run_pulse)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (step_btn),
    .level_o(step_level_unused),
    .rise_o (step_pulse)
  );

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    core_state_t   state_q;
    core_state_t   state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          step_d;
    logic          rst_q;
    logic          en_q;

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      step_d  = 1'b0;
      if (soft_reset[i]) begin
        state_d = RESET;
        hold_d  = HOLD_LOAD;
      end else if (state_q != RESET && !load_done[i]) begin
        state_d = RESET;
        hold_d  = HOLD_LOAD;
      end else begin
        case (state_q)
          RESET: begin
            if (hold_q != '0) begin
              hold_d = hold_q - 1'b1;
            end else if (load_done[i]) begin
              state_d = ARMED;
            end
          end
          ARMED: begin
            if (run_pulse) state_d = RUNNING;
          end
          RUNNING: begin
            if (run_pulse) state_d = HALTED;
          end
          HALTED: begin
            // A coincident run press takes precedence and swallows the step.
            if (run_pulse) begin
              state_d = RUNNING;
            end else if (step_pulse) begin
              step_d = 1'b1;
            end
          end
          default: state_d = RESET;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= RESET;
        hold_q  <= HOLD_LOAD;
        rst_q   <= 1'b1;
        en_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        rst_q   <= (state_d == RESET) || (state_d == ARMED);
        en_q    <= (state_d == RUNNING) || step_d;
      end
    end

    assign cpu_reset[i]        = rst_q;
    assign cpu_en[i]           = en_q;
    assign core_state[2*i +: 2] = state_q;
  end

endmodule
